expu_lanes_pipe: RTL and testbench

EXPU_LANES_PIPE -- requirements
Module: expu_lanes_pipe

---
 rtl/expu_lanes_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_expu_lanes_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expu_lanes_pipe.sv
// Multi-lane Schraudolph exponential unit behind an elastic valid/ready pipeline.
// Define EXPU_LANES_MANT_CORRECTION_EN to add the mantissa-correction core after each lane.

package expu_lanes_pkg;
    typedef enum logic [0:0] {
        FP_BF16 = 1'b0,
        FP_FP16 = 1'b1
    } fp_format_e;

    localparam fp_format_e FPFORMAT_IN = FP_BF16;

    function automatic int unsigned fp_exp_bits(fp_format_e fmt);
        return (fmt == FP_BF16) ? 8 : 5;
    endfunction

    function automatic int unsigned fp_man_bits(fp_format_e fmt);
        return (fmt == FP_BF16) ? 7 : 10;
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + fp_exp_bits(fmt) + fp_man_bits(fmt);
    endfunction
endpackage

// exp(x) ~= bits(x * 2^MAN_BITS / ln2 + bias << MAN_BITS), saturating to +inf / +0.
module expu_schraudolph #(
    parameter int unsigned EXP_BITS = 8,
    parameter int unsigned MAN_BITS = 7
) (
    input  logic [EXP_BITS+MAN_BITS:0] op_i,
    output logic [EXP_BITS+MAN_BITS:0] res_o
);
    localparam int unsigned BIAS    = (1 << (EXP_BITS - 1)) - 1;
    localparam int unsigned SAT_EXP = BIAS + EXP_BITS - 1;
    localparam logic [31:0] LOG2E   = 32'd1477;  // log2(e) with 10 fraction bits
    localparam logic [31:0] BASE    = 32'(BIAS) << MAN_BITS;
    localparam logic [31:0] MAX_RES = 32'((1 << EXP_BITS) - 1) << MAN_BITS;

    logic [EXP_BITS-1:0] exp_field;
    logic [31:0]         prod, scaled, sum, acc;
    logic                sat;

    always_comb begin
        exp_field = op_i[EXP_BITS+MAN_BITS-1 -: EXP_BITS];
        prod      = 32'({1'b1, op_i[MAN_BITS-1:0]}) * LOG2E;
        sat       = 32'(exp_field) >= SAT_EXP;
        scaled    = '0;
        if (exp_field != '0 && !sat) begin
            scaled = prod >> (32'(BIAS + 10) - 32'(exp_field));
        end
        sum = BASE + scaled;
        if (!op_i[EXP_BITS+MAN_BITS]) begin
            acc = (sat || sum >= MAX_RES) ? MAX_RES : sum;
        end else begin
            acc = (sat || scaled >= BASE) ? '0 : BASE - scaled;
        end
        res_o = {1'b0, acc[EXP_BITS+MAN_BITS-1:0]};
    end
endmodule

`ifdef EXPU_LANES_MANT_CORRECTION_EN
// Bends the linear 1+f mantissa toward 2^f by adding alpha*f*(1-f).
module expu_mant_correction #(
    parameter int unsigned EXP_BITS    = 8,
    parameter int unsigned MAN_BITS    = 7,
    parameter int unsigned ALPHA_NUM   = 11,
    parameter int unsigned ALPHA_SHIFT = 5
) (
    input  logic [EXP_BITS+MAN_BITS:0] op_i,
    output logic [EXP_BITS+MAN_BITS:0] res_o
);
    logic [31:0] mant, corr;

    always_comb begin
        mant  = 32'(op_i[MAN_BITS-1:0]);
        corr  = (mant * ((32'd1 << MAN_BITS) - mant) * ALPHA_NUM) >> (MAN_BITS + ALPHA_SHIFT);
        res_o = {op_i[EXP_BITS+MAN_BITS:MAN_BITS], MAN_BITS'(mant + corr)};
    end
endmodule
`endif

module expu_lanes_pipe
    import expu_lanes_pkg::*;
#(
    parameter fp_format_e  FPFORMAT   = FPFORMAT_IN,
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned NUM_REGS   = 2,
    parameter int unsigned COMB_STAGE = 0,
    localparam int unsigned WIDTH     = fp_width(FPFORMAT),
    localparam int unsigned OCC_W     = $clog2(NUM_REGS + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [NUM_LANES*WIDTH-1:0] op_i,
    input  logic [NUM_LANES-1:0]       strb_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [NUM_LANES*WIDTH-1:0] res_o,
    output logic [NUM_LANES-1:0]       strb_o,
    output logic                       busy_o,
    output logic [OCC_W-1:0]           occupancy_o
);
    localparam int unsigned EXP_BITS = fp_exp_bits(FPFORMAT);
    localparam int unsigned MAN_BITS = fp_man_bits(FPFORMAT);
    localparam int unsigned DW       = NUM_LANES * WIDTH;

    logic [NUM_REGS-1:0]  valid_q, valid_d, stage_rdy, src_valid, load_en;
    logic [DW-1:0]        data_q [NUM_REGS];
    logic [DW-1:0]        data_d [NUM_REGS];
    logic [DW-1:0]        src_data [NUM_REGS];
    logic [NUM_LANES-1:0] strb_q [NUM_REGS];
    logic [NUM_LANES-1:0] strb_d [NUM_REGS];
    logic [NUM_LANES-1:0] src_strb [NUM_REGS];
    logic [DW-1:0]        dp_in, dp_out;
    logic [NUM_LANES-1:0] dp_strb;

    if (COMB_STAGE == 0) begin : g_dp_from_ports
        assign dp_in   = op_i;
        assign dp_strb = strb_i;
    end else begin : g_dp_from_stage
        assign dp_in   = data_q[COMB_STAGE-1];
        assign dp_strb = strb_q[COMB_STAGE-1];
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [WIDTH-1:0] lane_in, lane_exp, lane_res;

        assign lane_in = dp_strb[k] ? dp_in[k*WIDTH +: WIDTH] : '0;

        expu_schraudolph #(.EXP_BITS(EXP_BITS), .MAN_BITS(MAN_BITS)) u_core (
            .op_i (lane_in),
            .res_o(lane_exp)
        );
`ifdef EXPU_LANES_MANT_CORRECTION_EN
        expu_mant_correction #(.EXP_BITS(EXP_BITS), .MAN_BITS(MAN_BITS)) u_corr (
            .op_i (lane_exp),
            .res_o(lane_res)
        );
`else
        assign lane_res = lane_exp;
`endif
        // Disabled lanes must read zero even though exp(0) is one.
        assign dp_out[k*WIDTH +: WIDTH] = dp_strb[k] ? lane_res : '0;
    end

    for (genvar s = 0; s < NUM_REGS; s++) begin : g_stage_src
        if (s == 0) begin : g_valid_in
            assign src_valid[s] = valid_i;
        end else begin : g_valid_prev
            assign src_valid[s] = valid_q[s-1];
        end
        if (s == COMB_STAGE) begin : g_from_dp
            assign src_data[s] = dp_out;
            assign src_strb[s] = dp_strb;
        end else if (s == 0) begin : g_from_ports
            assign src_data[s] = op_i;
            assign src_strb[s] = strb_i;
        end else begin : g_from_prev
            assign src_data[s] = data_q[s-1];
            assign src_strb[s] = strb_q[s-1];
        end
    end

    // Flattened form of r[s] = ~v[s] | r[s+1]: ready if ready_i or any hole at or after s.
    always_comb begin
        stage_rdy = '0;
        for (int s = 0; s < NUM_REGS; s++) begin
            stage_rdy[s] = ready_i;
            for (int j = s; j < NUM_REGS; j++) begin
                if (!valid_q[j]) stage_rdy[s] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_REGS; s++) begin
            valid_d[s] = clear_i ? 1'b0 : (stage_rdy[s] ? src_valid[s] : valid_q[s]);
            load_en[s] = clear_i | (stage_rdy[s] & src_valid[s]);
            data_d[s]  = clear_i ? '0 : src_data[s];
            strb_d[s]  = clear_i ? '0 : src_strb[s];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            // NOTE: data is reset too so res_o reads zero while idle, not stale results.
            for (int s = 0; s < NUM_REGS; s++) begin
                data_q[s] <= '0;
                strb_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every stage samples its upstream's pre-edge value.
            valid_q <= valid_d;
            for (int s = 0; s < NUM_REGS; s++) begin
                if (load_en[s]) begin
                    data_q[s] <= data_d[s];
                    strb_q[s] <= strb_d[s];
                end
            end
        end
    end

    if (COMB_STAGE == NUM_REGS) begin : g_out_dp
        assign res_o  = dp_out;
        assign strb_o = dp_strb;
    end else begin : g_out_stage
        assign res_o  = data_q[NUM_REGS-1];
        assign strb_o = strb_q[NUM_REGS-1];
    end

    assign ready_o = stage_rdy[0];
    assign valid_o = valid_q[NUM_REGS-1];
    assign busy_o  = |valid_q;

    always_comb begin
        occupancy_o = '0;
        for (int s = 0; s < NUM_REGS; s++) begin
            occupancy_o = occupancy_o + OCC_W'(valid_q[s]);
        end
    end
endmodule

// File: tb/tb_expu_lanes_pipe.sv
// Scoreboard bench for expu_lanes_pipe: BF16, 4 lanes, 2 stages, COMB_STAGE 0..2 in parallel.
module tb_expu_lanes_pipe;
    localparam int NL = 4;
    localparam int NR = 2;
    localparam int ND = NR + 1;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  strb;
        int          cyc;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_ni, clear_i, valid_i, ready_i;
    logic [63:0] op_i;
    logic [3:0]  strb_i;
    logic        ready_o_a [ND];
    logic        valid_o_a [ND];
    logic [63:0] res_o_a   [ND];
    logic [3:0]  strb_o_a  [ND];
    logic        busy_o_a  [ND];
    logic [1:0]  occ_a     [ND];

    beat_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pops = 0;
    bit          chk_latency = 0;
    logic [63:0] last_res;
    logic [3:0]  last_strb;
    logic        obs_ready, obs_valid;
    logic [1:0]  obs_occ;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        expu_lanes_pipe #(.NUM_LANES(NL), .NUM_REGS(NR), .COMB_STAGE(g)) u_dut (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (clear_i),
            .valid_i    (valid_i),
            .ready_o    (ready_o_a[g]),
            .op_i       (op_i),
            .strb_i     (strb_i),
            .valid_o    (valid_o_a[g]),
            .ready_i    (ready_i),
            .res_o      (res_o_a[g]),
            .strb_o     (strb_o_a[g]),
            .busy_o     (busy_o_a[g]),
            .occupancy_o(occ_a[g])
        );
    end

    // Golden BF16 Schraudolph: floor(|x| * 1477/1024 * 128) around 0x3F80, clamped to [0, 0x7F80].
    function automatic logic [15:0] exp_bf16(logic [15:0] op);
        int     e = int'(op[14:7]);
        int     m = int'(op[6:0]);
        real    mag;
        longint y;
        longint r;
        if (e == 0) y = 0;
        else begin
            mag = real'(128 + m) * (2.0 ** (e - 134));
            y   = (mag > 1.0e6) ? 64'd100000000 : longint'($floor(mag * 1477.0 / 8.0));
        end
        if (!op[15]) r = (16256 + y >= 32640) ? 32640 : 16256 + y;
        else         r = (y >= 16256) ? 0 : 16256 - y;
        return 16'(r);
    endfunction

    function automatic logic [63:0] exp_lanes(logic [63:0] op, logic [3:0] strb);
        logic [63:0] r = '0;
        for (int k = 0; k < NL; k++) r[k*16 +: 16] = strb[k] ? exp_bf16(op[k*16 +: 16]) : 16'h0;
        return r;
    endfunction

    function automatic logic [15:0] rand_op();
        logic [7:0] e = 8'($urandom_range(118, 135));
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    function automatic logic [63:0] rand_ops();
        return {rand_op(), rand_op(), rand_op(), rand_op()};
    endfunction

    // One clock: sample at negedge, run the scoreboard, drive again 1 unit after posedge.
    task automatic step(output bit in_fire);
        beat_t exp_b;
        @(negedge clk_i);
        obs_ready = ready_o_a[0];
        obs_valid = valid_o_a[0];
        obs_occ   = occ_a[0];
        for (int g = 1; g < ND; g++) begin
            checks++;
            if (valid_o_a[g] !== valid_o_a[0] || ready_o_a[g] !== ready_o_a[0] ||
                occ_a[g] !== occ_a[0] || busy_o_a[g] !== busy_o_a[0]) begin
                errors++;
                $display("FAIL handshake_agree dut%0d: v=%b r=%b occ=%0d busy=%b required v=%b r=%b occ=%0d busy=%b",
                         g, valid_o_a[g], ready_o_a[g], occ_a[g], busy_o_a[g],
                         valid_o_a[0], ready_o_a[0], occ_a[0], busy_o_a[0]);
            end
        end
        if (valid_o_a[0] && ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_beat: valid_o=1 required no beat (res=%h)", res_o_a[0]);
            end else begin
                exp_b = sb.pop_front();
                for (int g = 0; g < ND; g++) begin
                    checks++;
                    if (res_o_a[g] !== exp_b.res || strb_o_a[g] !== exp_b.strb) begin
                        errors++;
                        $display("FAIL beat_data dut%0d: res=%h strb=%b required res=%h strb=%b",
                                 g, res_o_a[g], strb_o_a[g], exp_b.res, exp_b.strb);
                    end
                end
                if (chk_latency) begin
                    checks++;
                    if (cyc - exp_b.cyc != NR) begin
                        errors++;
                        $display("FAIL latency: %0d cycles required %0d", cyc - exp_b.cyc, NR);
                    end
                end
                last_res  = res_o_a[0];
                last_strb = strb_o_a[0];
                pops++;
            end
        end
        in_fire = valid_i && ready_o_a[0] && !clear_i;
        if (in_fire) sb.push_back('{exp_lanes(op_i, strb_i), strb_i, cyc});
        if (clear_i) sb.delete();
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        bit f;
        valid_i = 0; clear_i = 0; ready_i = 1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step(f);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding required 0", sb.size());
        end
    endtask

    task automatic check_idle_outputs(string tag);
        for (int g = 0; g < ND; g++) begin
            checks++;
            if (valid_o_a[g] !== 1'b0 || res_o_a[g] !== 64'h0 || strb_o_a[g] !== 4'h0 ||
                busy_o_a[g] !== 1'b0 || occ_a[g] !== 2'd0 || ready_o_a[g] !== 1'b1) begin
                errors++;
                $display("FAIL %s dut%0d: v=%b res=%h strb=%b busy=%b occ=%0d rdy=%b required 0/0/0/0/0/1",
                         tag, g, valid_o_a[g], res_o_a[g], strb_o_a[g], busy_o_a[g], occ_a[g], ready_o_a[g]);
            end
        end
    endtask

    task automatic test_reset();
        bit f;
        rst_ni = 0; clear_i = 0; valid_i = 0; ready_i = 0; op_i = '0; strb_i = '0;
        #3;
        check_idle_outputs("reset_state");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i);
        #1;
        step(f);
        checks++;
        if (obs_ready !== 1'b1 || obs_occ !== 2'd0) begin
            errors++;
            $display("FAIL post_reset: ready_o=%b occ=%0d required 1 0", obs_ready, obs_occ);
        end
    endtask

    task automatic test_zero_ops();
        bit f;
        int p0 = pops;
        chk_latency = 1;
        ready_i = 1; valid_i = 1; op_i = '0; strb_i = 4'hF;
        step(f);
        valid_i = 0;
        for (int i = 0; i < 10 && pops == p0; i++) step(f);
        chk_latency = 0;
        checks++;
        if (pops != p0 + 1 || last_res !== {4{16'h3F80}}) begin
            errors++;
            $display("FAIL zero_ops: beats=%0d res=%h required 1 %h", pops - p0, last_res, {4{16'h3F80}});
        end
    endtask

    task automatic test_strobe();
        bit f;
        logic [63:0] ops;
        for (int k = 0; k < NL; k++) ops[k*16 +: 16] = {1'b0, 8'd126, 7'(k + 9)};
        ready_i = 1; valid_i = 1; op_i = ops; strb_i = 4'b0101;
        step(f);
        drain();
        checks++;
        if (last_res[31:16] !== 16'h0 || last_res[63:48] !== 16'h0 || last_strb !== 4'b0101) begin
            errors++;
            $display("FAIL strobe: lane1=%h lane3=%h strb=%b required 0000 0000 0101",
                     last_res[31:16], last_res[63:48], last_strb);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ops [10];
        bit acc;
        int sent = 0, c = 0, max_occ = 0, bad_rdy = 0, p0 = pops;
        for (int i = 0; i < 10; i++) ops[i] = rand_ops();
        while (sent < 10 && c < 100) begin
            ready_i = !(c >= 3 && c <= 6);
            valid_i = 1; op_i = ops[sent]; strb_i = 4'hF;
            step(acc);
            if (int'(obs_occ) > max_occ) max_occ = int'(obs_occ);
            if (!obs_ready && obs_occ != 2'd2) bad_rdy++;
            if (acc) sent++;
            c++;
        end
        drain();
        checks++;
        if (sent != 10 || pops - p0 != 10) begin
            errors++;
            $display("FAIL b2b_count: sent=%0d out=%0d required 10 10", sent, pops - p0);
        end
        checks++;
        if (max_occ != 2 || bad_rdy != 0) begin
            errors++;
            $display("FAIL b2b_occ: max_occ=%0d early_not_ready=%0d required 2 0", max_occ, bad_rdy);
        end
    endtask

    task automatic test_bubble();
        bit acc;
        ready_i = 0; valid_i = 1; op_i = rand_ops(); strb_i = 4'hF;
        step(acc);
        valid_i = 0;
        step(acc);
        valid_i = 1; op_i = rand_ops(); strb_i = 4'b1011;
        step(acc);
        checks++;
        if (!acc || obs_valid !== 1'b1 || obs_occ !== 2'd1) begin
            errors++;
            $display("FAIL bubble_park: accept=%0d valid_o=%b occ=%0d required 1 1 1", acc, obs_valid, obs_occ);
        end
        valid_i = 0;
        step(acc);
        checks++;
        if (obs_occ !== 2'd2 || obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL bubble_fill: occ=%0d ready_o=%b required 2 0", obs_occ, obs_ready);
        end
        drain();
    endtask

    task automatic test_clear();
        bit f;
        int p0;
        ready_i = 1; valid_i = 1; strb_i = 4'hF;
        op_i = rand_ops(); step(f);
        op_i = rand_ops(); step(f);
        op_i = rand_ops(); clear_i = 1; step(f);
        clear_i = 0; valid_i = 0;
        p0 = pops;
        step(f);
        checks++;
        if (obs_occ !== 2'd0 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_flush: occ=%0d valid_o=%b required 0 0", obs_occ, obs_valid);
        end
        for (int i = 0; i < 4; i++) step(f);
        checks++;
        if (pops != p0) begin
            errors++;
            $display("FAIL clear_leak: %0d beats after clear required 0", pops - p0);
        end
    endtask

    task automatic test_async_reset();
        bit f;
        int p0;
        ready_i = 1; valid_i = 1; strb_i = 4'hF;
        for (int i = 0; i < 3; i++) begin op_i = rand_ops(); step(f); end
        #2 rst_ni = 0;
        #1;
        check_idle_outputs("async_reset");
        sb.delete();
        valid_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i);
        #1;
        p0 = pops;
        for (int i = 0; i < 4; i++) step(f);
        checks++;
        if (pops != p0 || obs_occ !== 2'd0) begin
            errors++;
            $display("FAIL reset_discard: %0d beats occ=%0d required 0 0", pops - p0, obs_occ);
        end
    endtask

    task automatic test_random();
        bit f;
        for (int i = 0; i < 80; i++) begin
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 6);
            clear_i = ($urandom_range(0, 29) == 0);
            op_i    = rand_ops();
            strb_i  = 4'($urandom_range(0, 15));
            step(f);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_zero_ops();
        test_strobe();
        test_back_to_back();
        test_bubble();
        test_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached required completion");
        $fatal(1, "timeout");
    end
endmodule
